// File: rtl/adsr_envelope.sv
// -----------------------------------------------------------------------------
// adsr_envelope
//   Amplitude stage that sits after the oscillator output mux. It replaces a
//   hard on/off key gate with an attack/decay/sustain/release envelope and
//   scales the selected signed sample by the current envelope level. The scaled
//   sample is registered before it goes to the DAC / I2S path.
//
// Ports
//   clk_48kHz  in   1            sample clock, one sample per cycle
//   rst_n      in   1            synchronous reset, active low
//   gate_i     in   1            key held (level), 1 = note on
//   sample_i   in   WIDTH_P      signed oscillator sample
//   sample_o   out  WIDTH_P      signed enveloped sample (1 clock latency)
//   env_o      out  ENV_WIDTH_P  current envelope level (0xFFFF ~= 1.0)
//   state_o    out  3            0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
//   active_o   out  1            1 whenever the envelope is not IDLE
// -----------------------------------------------------------------------------
module adsr_envelope #(
    parameter int                     WIDTH_P        = 24,
    parameter int                     ENV_WIDTH_P    = 16,
    parameter logic [ENV_WIDTH_P-1:0] ATTACK_STEP_P  = 16'h0100,
    parameter logic [ENV_WIDTH_P-1:0] DECAY_STEP_P   = 16'h0010,
    parameter logic [ENV_WIDTH_P-1:0] SUSTAIN_P      = 16'hC000,
    parameter logic [ENV_WIDTH_P-1:0] RELEASE_STEP_P = 16'h0008
) (
    input  logic                   clk_48kHz,
    input  logic                   rst_n,
    input  logic                   gate_i,
    input  logic [WIDTH_P-1:0]     sample_i,
    output logic [WIDTH_P-1:0]     sample_o,
    output logic [ENV_WIDTH_P-1:0] env_o,
    output logic [2:0]             state_o,
    output logic                   active_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    localparam logic [ENV_WIDTH_P-1:0] ENV_MAX = '1;

    state_e                   state_q, state_d;
    logic [ENV_WIDTH_P-1:0]   env_q, env_d;
    logic [WIDTH_P-1:0]       sample_q, sample_d;

    // One extra bit on the envelope arithmetic so saturation and underflow are
    // detected instead of wrapping.
    logic [ENV_WIDTH_P:0]     attack_sum;
    logic [ENV_WIDTH_P:0]     decay_diff;

    assign attack_sum = {1'b0, env_q} + {1'b0, ATTACK_STEP_P};
    assign decay_diff = {1'b0, env_q} - {1'b0, DECAY_STEP_P};

    // ---------------------------------------------------------------------
    // Next-state / next-envelope logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case statement can infer a latch.
        state_d = state_q;
        env_d   = env_q;

        unique case (state_q)
            ST_IDLE: begin
                env_d = '0;
                if (gate_i) begin
                    state_d = ST_ATTACK;
                end
            end

            ST_ATTACK: begin
                if (!gate_i) begin
                    state_d = ST_RELEASE;
                end else if (attack_sum >= {1'b0, ENV_MAX}) begin
                    env_d   = ENV_MAX;
                    state_d = ST_DECAY;
                end else begin
                    env_d = attack_sum[ENV_WIDTH_P-1:0];
                end
            end

            ST_DECAY: begin
                if (!gate_i) begin
                    state_d = ST_RELEASE;
                end else if (decay_diff[ENV_WIDTH_P] ||
                             (decay_diff[ENV_WIDTH_P-1:0] <= SUSTAIN_P)) begin
                    // Top bit set means the subtraction borrowed: clamp too.
                    env_d   = SUSTAIN_P;
                    state_d = ST_SUSTAIN;
                end else begin
                    env_d = decay_diff[ENV_WIDTH_P-1:0];
                end
            end

            ST_SUSTAIN: begin
                if (!gate_i) begin
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (gate_i) begin
                    // Retrigger continues from the current level, no click.
                    state_d = ST_ATTACK;
                end else if (env_q <= RELEASE_STEP_P) begin
                    env_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    env_d = env_q - RELEASE_STEP_P;
                end
            end

            default: begin
                env_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Sample scaling: signed sample times non-negative envelope fraction.
    // The envelope is zero-extended to a positive signed operand; the
    // arithmetic shift floors, so |result| never exceeds |sample_i|.
    // ---------------------------------------------------------------------
    logic signed [WIDTH_P+ENV_WIDTH_P:0] product;

    assign product  = $signed(sample_i) * $signed({1'b0, env_q});
    assign sample_d = WIDTH_P'(product >>> ENV_WIDTH_P);

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_48kHz) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            env_q    <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            env_q    <= env_d;
            sample_q <= sample_d;
        end
    end

    assign sample_o = sample_q;
    assign env_o    = env_q;
    assign state_o  = state_q;
    assign active_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// -----------------------------------------------------------------------------
// tb_adsr_envelope
//   Directed bench for adsr_envelope. The stimulus process pushes hand-computed
//   expectations, each tagged with the clock edge it applies to, into a
//   scoreboard queue; a monitor on the falling edge pops and compares them.
//   Step sizes are 0x1000 so envelope sequences are easy to follow by hand.
// -----------------------------------------------------------------------------
module tb_adsr_envelope;

    localparam int WIDTH_P     = 24;
    localparam int ENV_WIDTH_P = 16;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_DECAY   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic                   clk_48kHz;
    logic                   rst_n;
    logic                   gate_i;
    logic [WIDTH_P-1:0]     sample_i;
    logic [WIDTH_P-1:0]     sample_o;
    logic [ENV_WIDTH_P-1:0] env_o;
    logic [2:0]             state_o;
    logic                   active_o;

    adsr_envelope #(
        .WIDTH_P        (WIDTH_P),
        .ENV_WIDTH_P    (ENV_WIDTH_P),
        .ATTACK_STEP_P  (16'h1000),
        .DECAY_STEP_P   (16'h1000),
        .SUSTAIN_P      (16'hC000),
        .RELEASE_STEP_P (16'h1000)
    ) dut (
        .clk_48kHz (clk_48kHz),
        .rst_n     (rst_n),
        .gate_i    (gate_i),
        .sample_i  (sample_i),
        .sample_o  (sample_o),
        .env_o     (env_o),
        .state_o   (state_o),
        .active_o  (active_o)
    );

    initial begin
        clk_48kHz = 1'b0;
        forever #5 clk_48kHz = ~clk_48kHz;
    end

    // Rising-edge counter; an expectation tagged N describes the outputs
    // right after rising edge N.
    int cyc = 0;
    always @(posedge clk_48kHz) cyc <= cyc + 1;

    typedef struct {
        int                     at;
        string                  name;
        bit                     chk_st;
        logic [2:0]             st;
        logic [ENV_WIDTH_P-1:0] env;
        bit                     chk_smp;
        logic [WIDTH_P-1:0]     smp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Expect state/env/active after the next rising edge.
    task automatic exp_env(input string name, input logic [2:0] st,
                           input logic [ENV_WIDTH_P-1:0] env);
        exp_t e;
        e.at = cyc + 1; e.name = name;
        e.chk_st = 1'b1; e.st = st; e.env = env;
        e.chk_smp = 1'b0; e.smp = '0;
        sb.push_back(e);
    endtask

    // Expect sample_o after the next rising edge.
    task automatic exp_smp(input string name, input logic [WIDTH_P-1:0] smp);
        exp_t e;
        e.at = cyc + 1; e.name = name;
        e.chk_st = 1'b0; e.st = '0; e.env = '0;
        e.chk_smp = 1'b1; e.smp = smp;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_48kHz);
        #1;
    endtask

    // Monitor: compare every expectation due at this cycle.
    exp_t m;
    always @(negedge clk_48kHz) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            m = sb.pop_front();
            if (m.at < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s@%0d: expectation not compared (now %0d)",
                         m.name, m.at, cyc);
            end else begin
                if (m.chk_st) begin
                    check($sformatf("%s@%0d state", m.name, m.at),
                          32'(state_o), 32'(m.st));
                    check($sformatf("%s@%0d env", m.name, m.at),
                          32'(env_o), 32'(m.env));
                    check($sformatf("%s@%0d active", m.name, m.at),
                          32'(active_o), 32'(m.st != S_IDLE));
                end
                if (m.chk_smp) begin
                    check($sformatf("%s@%0d sample", m.name, m.at),
                          32'(sample_o), 32'(m.smp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending",
                 sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- Reset held 2 clocks with gate high and a non-zero sample ----
        rst_n = 1'b0; gate_i = 1'b1; sample_i = 24'h400000;
        exp_env("reset", S_IDLE, 16'h0000); exp_smp("reset", 24'h000000);
        tick();
        exp_env("reset", S_IDLE, 16'h0000); exp_smp("reset", 24'h000000);
        tick();

        // ---- Attack from 0 with gate held ----
        rst_n = 1'b1; sample_i = '0;
        exp_env("attack_enter", S_ATTACK, 16'h0000);
        tick();
        sample_i = 24'h7FFFFF;                 // env is 0 here: output must be 0
        exp_smp("env_zero", 24'h000000);
        exp_env("attack", S_ATTACK, 16'h1000);
        tick();
        sample_i = '0;
        for (int k = 2; k <= 15; k++) begin
            exp_env("attack", S_ATTACK, 16'(k * 16'h1000));
            tick();
        end
        exp_env("attack_sat", S_DECAY, 16'hFFFF);
        tick();

        // ---- Decay to sustain; full-scale positive sample at env 0xFFFF ----
        sample_i = 24'h7FFFFF;
        exp_smp("full_pos", 24'h7FFF7F);
        exp_env("decay", S_DECAY, 16'hEFFF);
        tick();
        sample_i = '0;
        exp_env("decay", S_DECAY, 16'hDFFF);   tick();
        exp_env("decay", S_DECAY, 16'hCFFF);   tick();
        exp_env("sustain_clamp", S_SUSTAIN, 16'hC000); tick();

        // ---- Sustain hold with scaling checks at 0.75 ----
        sample_i = 24'h400000;
        exp_smp("scale_3q", 24'h300000);
        exp_env("sustain", S_SUSTAIN, 16'hC000);
        tick();
        sample_i = 24'hFFFFFF;                 // -1 * 0.75 floors to -1
        exp_smp("floor_neg", 24'hFFFFFF);
        exp_env("sustain", S_SUSTAIN, 16'hC000);
        tick();
        sample_i = '0;
        exp_env("sustain", S_SUSTAIN, 16'hC000);
        tick();

        // ---- Release, retrigger at 0x8000 ----
        gate_i = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            exp_env("release", S_RELEASE, 16'(16'hC000 - k * 16'h1000));
            tick();
        end
        gate_i = 1'b1;
        exp_env("retrigger", S_ATTACK, 16'h8000);
        tick();
        for (int k = 1; k <= 7; k++) begin
            exp_env("reattack", S_ATTACK, 16'(16'h8000 + k * 16'h1000));
            tick();
        end
        exp_env("reattack_sat", S_DECAY, 16'hFFFF);
        tick();

        // ---- Full-scale negative sample; gate drops and stays low ----
        sample_i = 24'h800000; gate_i = 1'b0;
        exp_smp("full_neg", 24'h800080);
        exp_env("release2", S_RELEASE, 16'hFFFF);
        tick();
        sample_i = '0;
        for (int k = 1; k <= 15; k++) begin
            exp_env("release2", S_RELEASE, 16'(16'hFFFF - k * 16'h1000));
            tick();
        end
        exp_env("release_end", S_IDLE, 16'h0000); tick();
        exp_env("idle_hold", S_IDLE, 16'h0000);   tick();

        // ---- One-cycle gate pulse: IDLE -> ATTACK -> RELEASE -> IDLE ----
        gate_i = 1'b1;
        exp_env("pulse", S_ATTACK, 16'h0000);  tick();
        gate_i = 1'b0;
        exp_env("pulse", S_RELEASE, 16'h0000); tick();
        exp_env("pulse", S_IDLE, 16'h0000);    tick();

        // ---- Mid-note reset during DECAY ----
        gate_i = 1'b1;
        exp_env("note3", S_ATTACK, 16'h0000);
        tick();
        for (int k = 1; k <= 15; k++) begin
            exp_env("note3", S_ATTACK, 16'(k * 16'h1000));
            tick();
        end
        exp_env("note3", S_DECAY, 16'hFFFF); tick();
        exp_env("note3", S_DECAY, 16'hEFFF); tick();
        rst_n = 1'b0; sample_i = 24'h400000;
        exp_env("midreset", S_IDLE, 16'h0000);
        exp_smp("midreset", 24'h000000);
        tick();
        rst_n = 1'b1; sample_i = '0;
        exp_env("post_reset", S_ATTACK, 16'h0000); tick();
        exp_env("post_reset", S_ATTACK, 16'h1000); tick();

        // ---- Drain: allow the monitor a bounded number of cycles ----
        for (int i = 0; i < 5 && sb.size() > 0; i++) tick();
        while (sb.size() > 0) begin
            m = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s@%0d: expectation never compared", m.name, m.at);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
